// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared register map, control/status bits and FSM encoding
package mul_pkg;

    localparam logic [2:0] ADDR_X       = 3'd0;
    localparam logic [2:0] ADDR_Y       = 3'd1;
    localparam logic [2:0] ADDR_PROD_LO = 3'd2;
    localparam logic [2:0] ADDR_PROD_HI = 3'd3;
    localparam logic [2:0] ADDR_CTRL    = 3'd4;

    localparam int CTRL_START  = 0;
    localparam int CTRL_SIGNED = 1;

    localparam int STAT_BUSY   = 0;
    localparam int STAT_DONE   = 1;
    localparam int STAT_SIGNED = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } mul_state_t;

endpackage

// File: rtl/shift_add_core.sv
// rtl/shift_add_core.sv - one-bit-per-cycle shift-add multiplier with sign fix-up
module shift_add_core
    import mul_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    output logic                 busy,
    output logic                 fix_done,
    output logic [2*WIDTH-1:0]   prod
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    mul_state_t state, state_next;

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      count;
    logic               neg;

    // -2^(W-1) negates to itself, which is the correct unsigned magnitude
    logic [WIDTH-1:0] x_mag, y_mag;
    assign x_mag = (signed_mode && x[WIDTH-1]) ? -x : x;
    assign y_mag = (signed_mode && y[WIDTH-1]) ? -y : y;

    always_comb begin
        state_next = state;
        busy       = 1'b1;
        fix_done   = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_next = RUN;
            end
            RUN: begin
                if (count == LAST) state_next = FIX;
            end
            FIX: begin
                fix_done   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
            neg    <= 1'b0;
            prod   <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc    <= '0;
                        mcand  <= {{WIDTH{1'b0}}, x_mag};
                        mplier <= y_mag;
                        count  <= '0;
                        neg    <= signed_mode & (x[WIDTH-1] ^ y[WIDTH-1]);
                    end
                end
                RUN: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 1'b1;
                end
                FIX: begin
                    prod <= neg ? -acc : acc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/seq_mul_unit.sv
// rtl/seq_mul_unit.sv - bus-mapped sequential multiplier: register file, status and read port
module seq_mul_unit
    import mul_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             E,
    input  logic             W,
    input  logic             R,
    input  logic [2:0]       ADDR,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] OUT,
    output logic             IRQ
);

    logic [WIDTH-1:0]   x_reg, y_reg;
    logic               signed_reg;
    logic               done_reg;
    logic               busy;
    logic               fix_done;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   rdata;

    logic wr_ok, start_acc, status_rd;
    assign wr_ok     = E & W & ~busy;
    assign start_acc = wr_ok & (ADDR == ADDR_CTRL) & D[CTRL_START];
    assign status_rd = E & R & (ADDR == ADDR_CTRL);

    shift_add_core #(.WIDTH(WIDTH)) u_core (
        .clk         (CLK),
        .rst         (RST),
        .start       (start_acc),
        .signed_mode (D[CTRL_SIGNED]),
        .x           (x_reg),
        .y           (y_reg),
        .busy        (busy),
        .fix_done    (fix_done),
        .prod        (prod)
    );

    always_comb begin
        rdata = '0;
        case (ADDR)
            ADDR_X:       rdata = x_reg;
            ADDR_Y:       rdata = y_reg;
            ADDR_PROD_LO: rdata = prod[WIDTH-1:0];
            ADDR_PROD_HI: rdata = prod[2*WIDTH-1:WIDTH];
            ADDR_CTRL: begin
                rdata[STAT_BUSY]   = busy;
                rdata[STAT_DONE]   = done_reg;
                rdata[STAT_SIGNED] = signed_reg;
            end
            default: rdata = '0;
        endcase
    end

    // Setting DONE on the FIX edge wins over a same-edge STATUS read clear
    always_ff @(posedge CLK) begin
        if (RST) begin
            x_reg      <= '0;
            y_reg      <= '0;
            signed_reg <= 1'b0;
            done_reg   <= 1'b0;
            OUT        <= '0;
        end else begin
            if (E && R) OUT <= rdata;
            if (wr_ok) begin
                case (ADDR)
                    ADDR_X:    x_reg      <= D;
                    ADDR_Y:    y_reg      <= D;
                    ADDR_CTRL: signed_reg <= D[CTRL_SIGNED];
                    default: ;
                endcase
            end
            if (fix_done)
                done_reg <= 1'b1;
            else if (start_acc || status_rd)
                done_reg <= 1'b0;
        end
    end

    assign IRQ = done_reg;

endmodule

// File: tb/tb_seq_mul_unit.sv
// tb/tb_seq_mul_unit.sv - scoreboard bench for seq_mul_unit with directed vectors
module tb_seq_mul_unit;

    localparam int WIDTH = 16;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             E = 1'b0, W = 1'b0, R = 1'b0;
    logic [2:0]       ADDR = 3'd0;
    logic [WIDTH-1:0] D = '0;
    logic [WIDTH-1:0] OUT;
    logic             IRQ;

    int n_vec  = 0;
    int n_fail = 0;

    logic [WIDTH-1:0] exp_q[$];
    string            name_q[$];

    seq_mul_unit #(.WIDTH(WIDTH)) dut (
        .CLK(CLK), .RST(RST), .E(E), .W(W), .R(R),
        .ADDR(ADDR), .D(D), .OUT(OUT), .IRQ(IRQ)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h", nm, act, exp);
        end
    endtask

    // Monitor: every sampled read presents OUT one edge later
    initial begin
        forever begin
            @(posedge CLK);
            if (E && R && !RST) begin
                #1;
                if (exp_q.size() == 0) begin
                    chk("unexpected_read", OUT, 'x);
                end else begin
                    chk(name_q.pop_front(), OUT, exp_q.pop_front());
                end
            end
        end
    end

    // Each bus op is driven at a negedge and occupies exactly the following posedge
    task automatic op(input logic e, input logic w, input logic r, input logic [2:0] a,
                      input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] exp, input string nm);
        @(negedge CLK);
        RST = 1'b0; E = e; W = w; R = r; ADDR = a; D = d;
        if (e && r) begin
            exp_q.push_back(exp);
            name_q.push_back(nm);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [WIDTH-1:0] d);
        op(1'b1, 1'b1, 1'b0, a, d, '0, "");
    endtask

    task automatic rd(input logic [2:0] a, input logic [WIDTH-1:0] exp, input string nm);
        op(1'b1, 1'b0, 1'b1, a, '0, exp, nm);
    endtask

    task automatic idle(input int n);
        repeat (n) op(1'b0, 1'b0, 1'b0, 3'd0, '0, '0, "");
    endtask

    task automatic chk_irq(input logic exp, input string nm);
        idle(1);
        chk(nm, {{(WIDTH-1){1'b0}}, IRQ}, {{(WIDTH-1){1'b0}}, exp});
    endtask

    // pre = bus edges already used after the START edge
    task automatic finish_run(input int pre, input logic sgn, input logic [2*WIDTH-1:0] exp_p, input string nm);
        logic [WIDTH-1:0] s;
        s = sgn ? 16'h0004 : 16'h0000;
        idle(14 - pre);
        chk_irq(1'b0, {nm, "_irq_early"});
        rd(3'd4, s | 16'h0001, {nm, "_busy16"});
        rd(3'd4, s | 16'h0001, {nm, "_stat_fix_edge"});
        chk_irq(1'b1, {nm, "_irq_done"});
        rd(3'd2, exp_p[WIDTH-1:0], {nm, "_lo"});
        rd(3'd3, exp_p[2*WIDTH-1:WIDTH], {nm, "_hi"});
        rd(3'd4, s | 16'h0002, {nm, "_stat_done"});
        rd(3'd4, s, {nm, "_stat_clr"});
        chk_irq(1'b0, {nm, "_irq_clr"});
    endtask

    task automatic run(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic sgn,
                       input logic [2*WIDTH-1:0] exp_p, input string nm);
        wr(3'd0, x);
        wr(3'd1, y);
        wr(3'd4, sgn ? 16'h0003 : 16'h0001);
        finish_run(0, sgn, exp_p, nm);
    endtask

    initial begin
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        chk("reset_out", OUT, '0);
        chk("reset_irq", {{(WIDTH-1){1'b0}}, IRQ}, '0);
        rd(3'd4, 16'h0000, "reset_status");
        rd(3'd2, 16'h0000, "reset_prod_lo");

        run(16'd4,     16'd5,     1'b0, 32'h0000_0014, "u4x5");
        run(16'd445,   16'd100,   1'b0, 32'h0000_ADD4, "u445x100");
        run(16'hFFFF,  16'hFFFF,  1'b0, 32'hFFFE_0001, "uffffxffff");
        run(16'hFFFD,  16'd7,     1'b1, 32'hFFFF_FFEB, "sm3x7");
        run(16'h8000,  16'h8000,  1'b1, 32'h4000_0000, "s8000x8000");
        run(16'h7FFF,  16'h8000,  1'b1, 32'hC000_8000, "s7fffx8000");

        // Bus corner cases
        wr(3'd5, 16'h1234);
        rd(3'd5, 16'h0000, "unmapped_rd");
        wr(3'd2, 16'h5555);
        rd(3'd2, 16'h8000, "prod_wr_ignored");
        wr(3'd0, 16'h00AA);
        op(1'b1, 1'b1, 1'b1, 3'd0, 16'h0055, 16'h00AA, "rw_same_edge_old");
        rd(3'd0, 16'h0055, "rw_same_edge_new");
        op(1'b0, 1'b0, 1'b1, 3'd1, '0, '0, "");
        idle(1);
        chk("e0_out_hold", OUT, 16'h0055);

        // Writes and re-START while busy are ignored
        wr(3'd0, 16'd3);
        wr(3'd1, 16'd5);
        wr(3'd4, 16'h0001);
        wr(3'd0, 16'd9);
        wr(3'd4, 16'h0003);
        finish_run(2, 1'b0, 32'h0000_000F, "busy_ign");
        rd(3'd0, 16'd3, "busy_x_kept");

        // Reset in the middle of a run
        wr(3'd0, 16'd7);
        wr(3'd1, 16'd6);
        wr(3'd4, 16'h0001);
        idle(7);
        @(negedge CLK);
        E = 1'b0; W = 1'b0; R = 1'b0; RST = 1'b1;
        chk_irq(1'b0, "rst_irq");
        chk("rst_out", OUT, '0);
        rd(3'd4, 16'h0000, "rst_status");
        rd(3'd0, 16'h0000, "rst_x");
        rd(3'd1, 16'h0000, "rst_y");
        rd(3'd2, 16'h0000, "rst_prod_lo");
        rd(3'd3, 16'h0000, "rst_prod_hi");
        idle(20);
        rd(3'd4, 16'h0000, "rst_no_done");
        run(16'd7, 16'd6, 1'b0, 32'h0000_002A, "after_rst");

        idle(3);
        chk("queue_drained", 16'(exp_q.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
